// File: rtl/setare_pkg.sv
// Shared types and limits for the time/alarm setting controller.
package setare_pkg;

    localparam int ORE_W = 5;
    localparam int MIN_W = 6;

    localparam int DEF_NUM_ALARMS     = 2;
    localparam int DEF_HOUR_MAX       = 23;
    localparam int DEF_MIN_MAX        = 59;
    localparam int DEF_REPEAT_DELAY   = 500;
    localparam int DEF_REPEAT_PERIOD  = 100;
    localparam int DEF_TIMEOUT_CYCLES = 30000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EDIT_TIME  = 2'd1,
        EDIT_ALARM = 2'd2
    } state_e;

    // Channel select width; a single channel still gets a 1-bit select.
    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/setare_multi_alarma_buton_repeat.sv
// Press-and-hold button: one pulse on the rising edge, then auto-repeat
// after REPEAT_DELAY held cycles and every REPEAT_PERIOD cycles after that.
module buton_repeat #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    input  logic repeat_en,
    output logic inc_pulse
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(CMAX + 1);

    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_q, rep_d;
    logic          rise;
    logic          hit;

    // cnt_q == 0 means "not armed": a press that started while repeat was
    // disabled never auto-repeats until it is released and pressed again.
    assign rise = btn & ~prev_q;
    assign hit  = btn & prev_q & repeat_en & (cnt_q != '0) &
                  (cnt_q == (rep_q ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY)));
    assign inc_pulse = rise | hit;

    always_comb begin
        cnt_d = cnt_q;
        rep_d = rep_q;
        if (!btn || !repeat_en) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (rise) begin
            cnt_d = CW'(1);
            rep_d = 1'b0;
        end else if (hit) begin
            cnt_d = CW'(1);
            rep_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            rep_q  <= 1'b0;
        end else begin
            prev_q <= btn;
            cnt_q  <= cnt_d;
            rep_q  <= rep_d;
        end
    end

endmodule

// File: rtl/setare_multi_alarma.sv
// Time/alarm edit controller: preload, hour/minute edit with auto-repeat,
// commit to the time counter or one of NUM_ALARMS alarm channels.
module setare_multi_alarma
    import setare_pkg::*;
#(
    parameter int NUM_ALARMS     = DEF_NUM_ALARMS,
    parameter int HOUR_MAX       = DEF_HOUR_MAX,
    parameter int MIN_MAX        = DEF_MIN_MAX,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int AW            = aw_of(NUM_ALARMS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        btn_set_time,
    input  logic                        btn_set_alarm,
    input  logic                        btn_hour,
    input  logic                        btn_min,
    input  logic                        btn_stop,
    input  logic                        btn_cancel,
    input  logic [ORE_W-1:0]            cur_ore,
    input  logic [MIN_W-1:0]            cur_minute,
    input  logic [ORE_W*NUM_ALARMS-1:0] alarm_ore_rd,
    input  logic [MIN_W*NUM_ALARMS-1:0] alarm_min_rd,
    output logic [ORE_W-1:0]            ore,
    output logic [MIN_W-1:0]            minute,
    output logic [AW-1:0]               alarm_sel,
    output logic                        editing,
    output logic                        load_timp,
    output logic [NUM_ALARMS-1:0]       load_alarma,
    output logic                        edit_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q, state_d;
    logic [ORE_W-1:0]      ore_q, ore_d;
    logic [MIN_W-1:0]      min_q, min_d;
    logic [AW-1:0]         sel_q, sel_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  ld_timp_q, ld_timp_d;
    logic [NUM_ALARMS-1:0] ld_alarma_q, ld_alarma_d;
    logic                  tout_q, tout_d;

    // {cancel, stop, set_alarm, set_time}
    logic [3:0]            btn_prev_q;
    logic                  st_e, sa_e, stop_e, cancel_e;
    logic                  hour_inc, min_inc, activity;
    logic [AW-1:0]         nxt_sel, ch;
    logic [ORE_W-1:0]      ch_ore;
    logic [MIN_W-1:0]      ch_min;

    assign st_e     = btn_set_time  & ~btn_prev_q[0];
    assign sa_e     = btn_set_alarm & ~btn_prev_q[1];
    assign stop_e   = btn_stop      & ~btn_prev_q[2];
    assign cancel_e = btn_cancel    & ~btn_prev_q[3];
    assign activity = st_e | sa_e | stop_e | cancel_e | hour_inc | min_inc;

    buton_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_hour (
        .clock(clock), .reset(reset), .btn(btn_hour), .repeat_en(editing), .inc_pulse(hour_inc)
    );

    buton_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_min (
        .clock(clock), .reset(reset), .btn(btn_min), .repeat_en(editing), .inc_pulse(min_inc)
    );

    // Preload source: channel 0 on alarm entry, the next channel when advancing.
    assign nxt_sel = (sel_q == AW'(NUM_ALARMS - 1)) ? '0 : sel_q + 1'b1;
    assign ch      = (state_q == IDLE) ? '0 : nxt_sel;
    assign ch_ore  = alarm_ore_rd[int'(ch)*ORE_W +: ORE_W];
    assign ch_min  = alarm_min_rd[int'(ch)*MIN_W +: MIN_W];

    always_comb begin
        state_d     = state_q;
        ore_d       = ore_q;
        min_d       = min_q;
        sel_d       = sel_q;
        tcnt_d      = '0;
        ld_timp_d   = 1'b0;
        ld_alarma_d = '0;
        tout_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_e) begin
                    state_d = EDIT_TIME;
                    ore_d   = cur_ore;
                    min_d   = cur_minute;
                end else if (sa_e) begin
                    state_d = EDIT_ALARM;
                    sel_d   = '0;
                    ore_d   = ch_ore;
                    min_d   = ch_min;
                end
            end
            default: begin
                if (cancel_e) begin
                    state_d = IDLE;
                end else if (stop_e) begin
                    state_d = IDLE;
                    if (state_q == EDIT_TIME) ld_timp_d = 1'b1;
                    else                      ld_alarma_d[sel_q] = 1'b1;
                end else if (!activity && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                end else if (state_q == EDIT_ALARM && sa_e) begin
                    sel_d = nxt_sel;
                    ore_d = ch_ore;
                    min_d = ch_min;
                end else begin
                    tcnt_d = activity ? '0 : tcnt_q + 1'b1;
                    if (hour_inc) ore_d = (ore_q == ORE_W'(HOUR_MAX)) ? '0 : ore_q + 1'b1;
                    if (min_inc)  min_d = (min_q == MIN_W'(MIN_MAX))  ? '0 : min_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ore_q       <= '0;
            min_q       <= '0;
            sel_q       <= '0;
            tcnt_q      <= '0;
            ld_timp_q   <= 1'b0;
            ld_alarma_q <= '0;
            tout_q      <= 1'b0;
            btn_prev_q  <= '0;
        end else begin
            state_q     <= state_d;
            ore_q       <= ore_d;
            min_q       <= min_d;
            sel_q       <= sel_d;
            tcnt_q      <= tcnt_d;
            ld_timp_q   <= ld_timp_d;
            ld_alarma_q <= ld_alarma_d;
            tout_q      <= tout_d;
            btn_prev_q  <= {btn_cancel, btn_stop, btn_set_alarm, btn_set_time};
        end
    end

    assign ore          = ore_q;
    assign minute       = min_q;
    assign alarm_sel    = sel_q;
    assign editing      = (state_q != IDLE);
    assign load_timp    = ld_timp_q;
    assign load_alarma  = ld_alarma_q;
    assign edit_timeout = tout_q;

endmodule
